unified_mem_arbiter: RTL and testbench

Parametrised single-port, byte-addressable unified instruction/data memory with a two-requester arbiter. It replaces the fixed half-rate clock-phase sharing of fetch and data access: both ports run at full `clk`, conflicts are resolved each cycle with data priority plus a starvation bound, and denied requesters see a stall. It sits between the IF stage (fetch port) and the MEM stage (load/store port) of the pipelined core.

---
 rtl/unified_mem_arbiter_if.sv | 36 +++
 rtl/unified_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_unified_mem_arbiter.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Fetch and load/store handshake bundle for the unified memory arbiter.
// master = pipeline side (IF/MEM stages), slave = memory/arbiter side.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 9
);
  // fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_stall;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  // load/store port
  logic              d_req;
  logic              d_we;
  logic [2:0]        d_funct3;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_stall;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;

  modport master (
    output if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
    input  if_gnt, if_stall, if_rvalid, if_rdata,
           d_gnt, d_stall, d_rvalid, d_rdata, d_err
  );

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_funct3, d_addr, d_wdata,
    output if_gnt, if_stall, if_rvalid, if_rdata,
           d_gnt, d_stall, d_rvalid, d_rdata, d_err
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Single-port byte-addressable unified I/D memory. Fetch and load/store share
// one access per cycle at full clk rate; data has priority except when fetch
// has been denied STARVE_LIMIT cycles in a row. Read latency is one cycle.
module unified_mem_arbiter #(
  parameter int    ADDR_W       = 9,
  parameter int    STARVE_LIMIT = 2,
  parameter string INIT_FILE    = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  unified_mem_arbiter_if.slave  bus
);
  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] LIM   = 4'(STARVE_LIMIT);

  logic [7:0] mem [DEPTH];

  logic [3:0]        starve_cnt;
  logic              if_gnt, d_gnt, starved;
  logic [ADDR_W-1:0] if_word_addr, acc_addr;
  logic [3:0][7:0]   rd_bytes;
  logic              acc_err, wr_en;
  logic [3:0]        be;
  logic [31:0]       ld_val;

  logic              if_rvalid_q, d_rvalid_q, d_err_q;
  logic [31:0]       if_rdata_q, d_rdata_q;

  // Grants are combinational and forced low while reset is held.
  assign starved = (starve_cnt == LIM);
  assign d_gnt   = ~reset & bus.d_req & ~(bus.if_req & starved);
  assign if_gnt  = ~reset & bus.if_req & ~d_gnt;

  assign bus.if_gnt    = if_gnt;
  assign bus.d_gnt     = d_gnt;
  assign bus.if_stall  = bus.if_req & ~if_gnt;
  assign bus.d_stall   = bus.d_req & ~d_gnt;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_err     = d_err_q;

  // The single array port goes to whichever requester won this cycle.
  assign if_word_addr = {bus.if_addr[ADDR_W-1:2], 2'b00};
  assign acc_addr     = d_gnt ? bus.d_addr : if_word_addr;

  // Four byte lanes starting at the access address, wrapping modulo depth.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    assign rd_bytes[k] = mem[acc_addr + ADDR_W'(k)];
  end

  // Misalignment and illegal funct3 detection for the data port.
  always_comb begin
    acc_err = 1'b0;
    if (bus.d_we) begin
      case (bus.d_funct3)
        3'b000:  acc_err = 1'b0;
        3'b001:  acc_err = bus.d_addr[0];
        3'b010:  acc_err = |bus.d_addr[1:0];
        default: acc_err = 1'b1;
      endcase
    end else begin
      case (bus.d_funct3)
        3'b000, 3'b100: acc_err = 1'b0;
        3'b001, 3'b101: acc_err = bus.d_addr[0];
        3'b010:         acc_err = |bus.d_addr[1:0];
        default:        acc_err = 1'b1;
      endcase
    end
  end

  // Load extension from the little-endian byte lanes.
  always_comb begin
    ld_val = 32'h0;
    case (bus.d_funct3)
      3'b000:  ld_val = {{24{rd_bytes[0][7]}}, rd_bytes[0]};
      3'b001:  ld_val = {{16{rd_bytes[1][7]}}, rd_bytes[1], rd_bytes[0]};
      3'b010:  ld_val = rd_bytes;
      3'b100:  ld_val = {24'h0, rd_bytes[0]};
      3'b101:  ld_val = {16'h0, rd_bytes[1], rd_bytes[0]};
      default: ld_val = 32'h0;
    endcase
  end

  // Byte enables relative to d_addr; erroring stores write nothing.
  always_comb begin
    case (bus.d_funct3)
      3'b000:  be = 4'b0001;
      3'b001:  be = 4'b0011;
      default: be = 4'b1111;
    endcase
    wr_en = d_gnt & bus.d_we & ~acc_err;
  end

  // Store bytes land at the edge closing the grant cycle.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_en && be[k]) mem[bus.d_addr + ADDR_W'(k)] <= bus.d_wdata[8*k +: 8];
    end
  end

  // Starvation counter plus registered responses; reset drops in-flight ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt  <= 4'd0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'h0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= 32'h0;
      d_err_q     <= 1'b0;
    end else begin
      if (!bus.if_req || if_gnt) starve_cnt <= 4'd0;
      else if (!starved)         starve_cnt <= starve_cnt + 4'd1;
      if_rvalid_q <= if_gnt;
      if (if_gnt) if_rdata_q <= rd_bytes;
      d_rvalid_q <= d_gnt;
      d_err_q    <= d_gnt & acc_err;
      if (d_gnt) d_rdata_q <= (bus.d_we || acc_err) ? 32'h0 : ld_val;
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: byte/half/word loads and stores,
// error cases, fetch streaming, starvation arbitration and mid-flight reset.
module tb_unified_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(9)) bus ();

  unified_mem_arbiter #(.ADDR_W(9), .STARVE_LIMIT(2), .INIT_FILE("")) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One data access: request, confirm grant, then check the registered response.
  task automatic dacc(input string tag, input logic we, input logic [2:0] f3,
                      input logic [8:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_funct3 = f3; bus.d_addr = a; bus.d_wdata = wd;
    #1;
    chk({tag, "_gnt"}, bus.d_gnt, 1);
    step();
    bus.d_req = 1'b0;
    chk({tag, "_rv"},  bus.d_rvalid, 1);
    chk({tag, "_rd"},  bus.d_rdata, exp_rd);
    chk({tag, "_err"}, bus.d_err, exp_err);
  endtask

  initial begin
    bus.if_req = 1'b1; bus.if_addr = '0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_funct3 = 3'b010; bus.d_addr = '0; bus.d_wdata = '0;
    reset = 1'b1;
    #12;
    // reset state with both requesting
    chk("rst_if_gnt",  bus.if_gnt, 0);
    chk("rst_d_gnt",   bus.d_gnt, 0);
    chk("rst_if_stall", bus.if_stall, 1);
    chk("rst_d_stall", bus.d_stall, 1);
    chk("rst_if_rv",   bus.if_rvalid, 0);
    chk("rst_d_rv",    bus.d_rvalid, 0);
    chk("rst_d_err",   bus.d_err, 0);
    chk("rst_if_rd",   bus.if_rdata, 0);
    chk("rst_d_rd",    bus.d_rdata, 0);
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    step();
    reset = 1'b0;
    step();

    // word store then every load flavour
    dacc("sw10",  1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0, 0);
    dacc("lb13",  0, 3'b000, 9'h013, 32'h0, 32'hFFFFFFDE, 0);
    dacc("lbu13", 0, 3'b100, 9'h013, 32'h0, 32'h000000DE, 0);
    dacc("lh12",  0, 3'b001, 9'h012, 32'h0, 32'hFFFFDEAD, 0);
    dacc("lhu12", 0, 3'b101, 9'h012, 32'h0, 32'h0000DEAD, 0);
    dacc("lw10",  0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 0);

    // byte store, misaligned half store, illegal funct3
    dacc("sb11",   1, 3'b000, 9'h011, 32'h00000055, 32'h0, 0);
    dacc("lw10b",  0, 3'b010, 9'h010, 32'h0, 32'hDEAD55EF, 0);
    dacc("sh11",   1, 3'b001, 9'h011, 32'h0000AAAA, 32'h0, 1);
    dacc("lw10c",  0, 3'b010, 9'h010, 32'h0, 32'hDEAD55EF, 0);
    dacc("ld011",  0, 3'b011, 9'h010, 32'h0, 32'h0, 1);
    dacc("st100",  1, 3'b100, 9'h010, 32'h12345678, 32'h0, 1);
    dacc("lw10d",  0, 3'b010, 9'h010, 32'h0, 32'hDEAD55EF, 0);
    dacc("lw11mis", 0, 3'b010, 9'h011, 32'h0, 32'h0, 1);
    step();
    chk("idle_d_rv",  bus.d_rvalid, 0);
    chk("idle_d_err", bus.d_err, 0);
    chk("idle_d_hold", bus.d_rdata, 0);

    // fetch streaming, 0x07 reads the word at 0x04
    dacc("sw00", 1, 3'b010, 9'h000, 32'h11223344, 32'h0, 0);
    dacc("sw04", 1, 3'b010, 9'h004, 32'h55667788, 32'h0, 0);
    begin
      logic [8:0]  fa [3];
      logic [31:0] fe [3];
      fa[0] = 9'h000; fa[1] = 9'h004; fa[2] = 9'h007;
      fe[0] = 32'h11223344; fe[1] = 32'h55667788; fe[2] = 32'h55667788;
      for (int i = 0; i < 3; i++) begin
        bus.if_req = 1'b1; bus.if_addr = fa[i];
        #1;
        chk($sformatf("f%0d_gnt", i), bus.if_gnt, 1);
        step();
        chk($sformatf("f%0d_rv", i), bus.if_rvalid, 1);
        chk($sformatf("f%0d_rd", i), bus.if_rdata, fe[i]);
        chk($sformatf("f%0d_drv", i), bus.d_rvalid, 0);
      end
      bus.if_req = 1'b0;
      step();
      chk("f_rv_end", bus.if_rvalid, 0);
      chk("f_rd_hold", bus.if_rdata, 32'h55667788);
    end

    // both requesting continuously: D,D,I repeating
    bus.if_req = 1'b1; bus.if_addr = 9'h000;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_funct3 = 3'b010; bus.d_addr = 9'h010;
    for (int i = 0; i < 6; i++) begin
      logic ig;
      ig = (i % 3 == 2);
      #1;
      chk($sformatf("arb%0d_ig", i), bus.if_gnt, ig);
      chk($sformatf("arb%0d_dg", i), bus.d_gnt, !ig);
      chk($sformatf("arb%0d_ist", i), bus.if_stall, !ig);
      chk($sformatf("arb%0d_cnt", i), dut.starve_cnt, i % 3);
      step();
      chk($sformatf("arb%0d_irv", i), bus.if_rvalid, ig);
      chk($sformatf("arb%0d_drv", i), bus.d_rvalid, !ig);
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    step();

    // reset lands before the response edge of a granted load
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_funct3 = 3'b010; bus.d_addr = 9'h010;
    #1;
    chk("rl_gnt", bus.d_gnt, 1);
    reset = 1'b1;
    #1;
    chk("rl_gnt_rst", bus.d_gnt, 0);
    step();
    bus.d_req = 1'b0;
    chk("rl_drv", bus.d_rvalid, 0);
    chk("rl_drd", bus.d_rdata, 0);
    chk("rl_err", bus.d_err, 0);
    chk("rl_ird", bus.if_rdata, 0);
    step();
    chk("rl_drv2", bus.d_rvalid, 0);
    reset = 1'b0;
    step();
    dacc("lw_after_rst", 0, 3'b010, 9'h010, 32'h0, 32'hDEAD55EF, 0);
    dacc("lw00_after",   0, 3'b010, 9'h000, 32'h0, 32'h11223344, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
